dma_bus_arbiter: RTL and testbench

Owns the shared data-memory port between the CPU data side and the DMA engine. It implements the BR/BG handshake and muxes the read, write and address signals to memory. It stalls the CPU while the DMA owns the bus and keeps a short CPU-guard window after each release. Sits between cpu, DMA and Memory at top level; the d_data bus stays tri-state, gated by the owner-enable outputs.

---
 rtl/dma_bus_arbiter_pkg.sv | 15 +
 rtl/dma_bus_arbiter_if.sv | 35 +++
 rtl/dma_bus_arbiter_sat_counter.sv | 25 ++
 rtl/dma_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types and defaults for the DMA/CPU data-memory bus arbiter.
//   arb_state_e       : arbiter FSM state encoding (2 bits)
//   WORD_SIZE_DEFAULT : default address / counter width
package dma_bus_arbiter_pkg;

  localparam int unsigned WORD_SIZE_DEFAULT = 16;

  typedef enum logic [1:0] {
    StCpuOwn  = 2'd0,  // CPU owns the memory port
    StDrain   = 2'd1,  // DMA requested, waiting for the CPU access to finish
    StDmaOwn  = 2'd2,  // DMA owns the memory port
    StRelease = 2'd3   // one-cycle turnaround, nobody drives d_data
  } arb_state_e;

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// Handshake and memory-port signals around the bus arbiter.
//   master modport : the arbiter (drives bg, cpu_stall, mem_* and bus enables)
//   slave modport  : CPU, DMA and memory side (drive requests, addresses, mem_ready)
interface dma_bus_arbiter_if
  import dma_bus_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEFAULT
) ();

  logic                 cpu_readM;
  logic                 cpu_writeM;
  logic [WORD_SIZE-1:0] cpu_address;
  logic                 dma_write;
  logic [WORD_SIZE-1:0] dma_address;
  logic                 br;
  logic                 bg;
  logic                 cpu_stall;
  logic                 mem_readM;
  logic                 mem_writeM;
  logic [WORD_SIZE-1:0] mem_address;
  logic                 mem_ready;
  logic                 cpu_bus_en;
  logic                 dma_bus_en;

  modport master (
    input  cpu_readM, cpu_writeM, cpu_address, dma_write, dma_address, br, mem_ready,
    output bg, cpu_stall, mem_readM, mem_writeM, mem_address, cpu_bus_en, dma_bus_en
  );

  modport slave (
    output cpu_readM, cpu_writeM, cpu_address, dma_write, dma_address, br, mem_ready,
    input  bg, cpu_stall, mem_readM, mem_writeM, mem_address, cpu_bus_en, dma_bus_en
  );

endinterface

// File: rtl/dma_bus_arbiter_sat_counter.sv
// Up-counter with synchronous clear and selectable wrap or saturate behaviour.
//   clk, reset_n : clock, synchronous active-low reset
//   clr          : synchronous clear (wins over inc)
//   inc          : count up by one this cycle
//   count        : current value; holds at all-ones when WRAP = 0
module arb_sat_counter #(
  parameter int unsigned WIDTH = 16,
  parameter bit          WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      count <= '0;
    end else if (inc && (WRAP || (count != '1))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Arbiter for the shared data-memory port between the CPU data side and the DMA.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : BR/BG handshake, CPU/DMA requests and the muxed memory port
//   grant_cnt    : number of grants to the DMA, wraps
//   stall_cnt    : cycles with cpu_stall = 1, saturates
//   dma_overrun  : sticky, DMA held the bus for MAX_HOLD or more cycles
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEFAULT,
  parameter int unsigned CPU_GUARD = 2,
  parameter int unsigned MAX_HOLD  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dma_bus_arbiter_if.master    bus,
  output logic [WORD_SIZE-1:0] grant_cnt,
  output logic [WORD_SIZE-1:0] stall_cnt,
  output logic                 dma_overrun
);

  // hold is compared before it increments, so the flag lands on the same edge
  // at which hold reaches MAX_HOLD.
  localparam int unsigned HoldLimit = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  arb_state_e           state_q, state_d;
  logic                 bg_q, cpu_stall_q, overrun_q;
  logic [WORD_SIZE-1:0] guard_q;
  logic [WORD_SIZE-1:0] hold;
  logic                 pending;
  logic                 grant_entry;
  arb_state_e           mux_sel;

  assign pending     = (bus.cpu_readM | bus.cpu_writeM) & ~bus.mem_ready;
  assign grant_entry = (state_d == StDmaOwn) && (state_q != StDmaOwn);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCpuOwn: begin
        // A request seen while the guard runs is dropped, not remembered.
        if (bus.br && (guard_q == '0)) begin
          state_d = pending ? StDrain : StDmaOwn;
        end
      end
      StDrain: begin
        if (!bus.br) begin
          state_d = StCpuOwn;
        end else if (bus.mem_ready) begin
          state_d = StDmaOwn;
        end
      end
      StDmaOwn: begin
        if (!bus.br) begin
          state_d = StRelease;
        end
      end
      StRelease: state_d = StCpuOwn;
      default:   state_d = StCpuOwn;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StCpuOwn;
      bg_q        <= 1'b0;
      cpu_stall_q <= 1'b0;
      guard_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bg_q        <= (state_d == StDmaOwn);
      cpu_stall_q <= (state_d == StDmaOwn) || (state_d == StRelease);
      if (state_q == StRelease) begin
        guard_q <= WORD_SIZE'(CPU_GUARD);
      end else if ((state_q == StCpuOwn) && (guard_q != '0)) begin
        guard_q <= guard_q - 1'b1;
      end
      if ((state_q == StDmaOwn) && bus.br && (hold >= WORD_SIZE'(HoldLimit))) begin
        overrun_q <= 1'b1;
      end
    end
  end

  arb_sat_counter #(
    .WIDTH (WORD_SIZE),
    .WRAP  (1'b1)
  ) u_grant_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .inc     (grant_entry),
    .count   (grant_cnt)
  );

  arb_sat_counter #(
    .WIDTH (WORD_SIZE),
    .WRAP  (1'b0)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .inc     (cpu_stall_q),
    .count   (stall_cnt)
  );

  arb_sat_counter #(
    .WIDTH (WORD_SIZE),
    .WRAP  (1'b0)
  ) u_hold_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_q == StRelease),
    .inc     (state_q == StDmaOwn),
    .count   (hold)
  );

  // Mux follows the state register only; while reset is held the CPU owns the
  // port even if the state register still says otherwise.
  assign mux_sel = reset_n ? state_q : StCpuOwn;

  always_comb begin
    bus.mem_readM   = 1'b0;
    bus.mem_writeM  = 1'b0;
    bus.mem_address = '0;
    bus.cpu_bus_en  = 1'b0;
    bus.dma_bus_en  = 1'b0;
    unique case (mux_sel)
      StCpuOwn, StDrain: begin
        bus.mem_readM   = bus.cpu_readM;
        bus.mem_writeM  = bus.cpu_writeM;
        bus.mem_address = bus.cpu_address;
        bus.cpu_bus_en  = 1'b1;
      end
      StDmaOwn: begin
        bus.mem_writeM  = bus.dma_write;
        bus.mem_address = bus.dma_address;
        bus.dma_bus_en  = 1'b1;
      end
      StRelease: ;
      default: ;
    endcase
  end

  assign bus.bg      = bg_q;
  assign bus.cpu_stall = cpu_stall_q;
  assign dma_overrun = overrun_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
module tb_dma_bus_arbiter;

  localparam int unsigned W     = 16;
  localparam int unsigned GUARD = 2;
  localparam int unsigned HOLD  = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dma_bus_arbiter_if #(.WORD_SIZE(W)) bus ();
  logic [W-1:0] grant_cnt, stall_cnt;
  logic         dma_overrun;

  dma_bus_arbiter #(
    .WORD_SIZE (W),
    .CPU_GUARD (GUARD),
    .MAX_HOLD  (HOLD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .grant_cnt   (grant_cnt),
    .stall_cnt   (stall_cnt),
    .dma_overrun (dma_overrun)
  );

  typedef struct {
    logic         bg, stl, rd, wr, cen, den, ovr;
    logic [W-1:0] addr, gcnt, scnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: 0 CPU_OWN, 1 DRAIN, 2 DMA_OWN, 3 RELEASE
  int           m_st, m_guard, m_hold;
  logic [W-1:0] m_gcnt, m_scnt;
  logic         m_ovr, m_bg, m_stl;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_guard = 0; m_hold = 0;
    m_gcnt = '0; m_scnt = '0;
    m_ovr = 1'b0; m_bg = 1'b0; m_stl = 1'b0;
  endtask

  // Drive one cycle, queue what the DUT should show during it, advance the model.
  task automatic step(input logic rd, input logic wr, input logic [W-1:0] ca, input logic dw,
                      input logic [W-1:0] da, input logic b, input logic rdy, input logic rn);
    exp_t e;
    int   nst;
    logic pend;
    bus.cpu_readM = rd; bus.cpu_writeM = wr; bus.cpu_address = ca;
    bus.dma_write = dw; bus.dma_address = da; bus.br = b; bus.mem_ready = rdy;
    reset_n = rn;
    e.bg = m_bg; e.stl = m_stl; e.gcnt = m_gcnt; e.scnt = m_scnt; e.ovr = m_ovr;
    if (!rn || m_st <= 1) begin
      e.rd = rd; e.wr = wr; e.addr = ca; e.cen = 1'b1; e.den = 1'b0;
    end else if (m_st == 2) begin
      e.rd = 1'b0; e.wr = dw; e.addr = da; e.cen = 1'b0; e.den = 1'b1;
    end else begin
      e.rd = 1'b0; e.wr = 1'b0; e.addr = '0; e.cen = 1'b0; e.den = 1'b0;
    end
    sb.push_back(e);
    if (!rn) begin
      model_reset();
    end else begin
      pend = (rd | wr) & ~rdy;
      nst  = m_st;
      if (m_stl && m_scnt != 16'hFFFF) m_scnt = m_scnt + 1'b1;
      case (m_st)
        0: if (m_guard > 0) m_guard = m_guard - 1;
           else if (b) nst = pend ? 1 : 2;
        1: if (!b) nst = 0;
           else if (rdy) nst = 2;
        2: begin
          if (m_hold < 65535) m_hold = m_hold + 1;
          if (b && m_hold >= HOLD) m_ovr = 1'b1;
          if (!b) nst = 3;
        end
        default: begin
          nst = 0; m_guard = GUARD; m_hold = 0;
        end
      endcase
      if (nst == 2 && m_st != 2) m_gcnt = m_gcnt + 1'b1;
      m_st  = nst;
      m_bg  = (nst == 2);
      m_stl = (nst >= 2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic b, input logic rd, input logic rdy, input logic [W-1:0] ca);
    step(rd, 1'b0, ca, 1'($urandom_range(0, 1)), 16'h01F4, b, rdy, 1'b1);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check_eq("sb_bg", 32'(bus.bg), 32'(mon_e.bg));
      check_eq("sb_cpu_stall", 32'(bus.cpu_stall), 32'(mon_e.stl));
      check_eq("sb_mem_readM", 32'(bus.mem_readM), 32'(mon_e.rd));
      check_eq("sb_mem_writeM", 32'(bus.mem_writeM), 32'(mon_e.wr));
      check_eq("sb_mem_address", 32'(bus.mem_address), 32'(mon_e.addr));
      check_eq("sb_cpu_bus_en", 32'(bus.cpu_bus_en), 32'(mon_e.cen));
      check_eq("sb_dma_bus_en", 32'(bus.dma_bus_en), 32'(mon_e.den));
      check_eq("sb_grant_cnt", 32'(grant_cnt), 32'(mon_e.gcnt));
      check_eq("sb_stall_cnt", 32'(stall_cnt), 32'(mon_e.scnt));
      check_eq("sb_dma_overrun", 32'(dma_overrun), 32'(mon_e.ovr));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_readM = 1'b0; bus.cpu_writeM = 1'b0; bus.cpu_address = 16'h0100;
    bus.dma_write = 1'b0; bus.dma_address = 16'h01F4; bus.br = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_eq("rst_bg", 32'(bus.bg), 32'd0);
    check_eq("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    check_eq("rst_grant_cnt", 32'(grant_cnt), 32'd0);
    check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check_eq("rst_overrun", 32'(dma_overrun), 32'd0);
    check_eq("rst_cpu_bus_en", 32'(bus.cpu_bus_en), 32'd1);
    check_eq("rst_dma_bus_en", 32'(bus.dma_bus_en), 32'd0);

    // Idle CPU, br at cycle 5: granted next cycle
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 16'h0100);
    cyc(1'b1, 1'b0, 1'b0, 16'h0100);
    check_eq("grant_bg", 32'(bus.bg), 32'd1);
    check_eq("grant_stall", 32'(bus.cpu_stall), 32'd1);
    check_eq("grant_addr", 32'(bus.mem_address), 32'h01F4);
    check_eq("grant_cnt1", 32'(grant_cnt), 32'd1);

    // br held 12 cycles in total, then dropped
    repeat (11) cyc(1'b1, 1'b0, 1'b0, 16'h0100);
    cyc(1'b0, 1'b0, 1'b0, 16'h0100);
    check_eq("rel_bg", 32'(bus.bg), 32'd0);
    check_eq("rel_stall", 32'(bus.cpu_stall), 32'd1);
    check_eq("rel_cpu_en", 32'(bus.cpu_bus_en), 32'd0);
    check_eq("rel_dma_en", 32'(bus.dma_bus_en), 32'd0);

    // br re-asserted straight away: guard holds it off for two CPU_OWN cycles
    cyc(1'b1, 1'b0, 1'b0, 16'h0100);
    check_eq("stall_cnt13", 32'(stall_cnt), 32'd13);
    check_eq("guard_bg0", 32'(bus.bg), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0100);
    check_eq("guard_bg1", 32'(bus.bg), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0100);
    check_eq("guard_bg2", 32'(bus.bg), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0100);
    check_eq("guard_grant_bg", 32'(bus.bg), 32'd1);
    check_eq("grant_cnt2", 32'(grant_cnt), 32'd2);

    // Long hold: overrun after 16 DMA_OWN cycles, sticky, never preempted
    repeat (15) cyc(1'b1, 1'b0, 1'b0, 16'h0100);
    check_eq("ovr_early", 32'(dma_overrun), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0100);
    check_eq("ovr_set", 32'(dma_overrun), 32'd1);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 16'h0100);
    check_eq("ovr_bg_held", 32'(bus.bg), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0100);
    cyc(1'b0, 1'b0, 1'b0, 16'h0100);
    check_eq("ovr_sticky", 32'(dma_overrun), 32'd1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 16'h0100);

    // Pending CPU read: drain until mem_ready, then grant
    cyc(1'b1, 1'b1, 1'b0, 16'h0200);
    check_eq("drain_bg", 32'(bus.bg), 32'd0);
    check_eq("drain_stall", 32'(bus.cpu_stall), 32'd0);
    check_eq("drain_addr", 32'(bus.mem_address), 32'h0200);
    cyc(1'b1, 1'b1, 1'b0, 16'h0200);
    check_eq("drain_addr2", 32'(bus.mem_address), 32'h0200);
    cyc(1'b1, 1'b1, 1'b1, 16'h0200);
    check_eq("drain_grant_bg", 32'(bus.bg), 32'd1);
    check_eq("drain_grant_cnt", 32'(grant_cnt), 32'd3);
    check_eq("drain_grant_addr", 32'(bus.mem_address), 32'h01F4);
    cyc(1'b0, 1'b0, 1'b0, 16'h0200);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 16'h0200);

    // Aborted drain: br withdrawn before mem_ready
    cyc(1'b1, 1'b1, 1'b0, 16'h0300);
    cyc(1'b0, 1'b1, 1'b0, 16'h0300);
    check_eq("abort_bg", 32'(bus.bg), 32'd0);
    check_eq("abort_cnt", 32'(grant_cnt), 32'd3);
    cyc(1'b0, 1'b1, 1'b1, 16'h0300);

    // Reset in the middle of DMA_OWN
    cyc(1'b1, 1'b0, 1'b0, 16'h0100);
    check_eq("pre_rst_bg", 32'(bus.bg), 32'd1);
    step(1'b0, 1'b0, 16'h0100, 1'b1, 16'h01F4, 1'b1, 1'b0, 1'b0);
    check_eq("mid_rst_bg", 32'(bus.bg), 32'd0);
    check_eq("mid_rst_stall", 32'(bus.cpu_stall), 32'd0);
    check_eq("mid_rst_gcnt", 32'(grant_cnt), 32'd0);
    check_eq("mid_rst_ovr", 32'(dma_overrun), 32'd0);
    check_eq("mid_rst_addr", 32'(bus.mem_address), 32'h0100);
    check_eq("mid_rst_dma_en", 32'(bus.dma_bus_en), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 80; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 2) == 0), 16'($urandom_range(0, 65535)));
    end

    @(negedge clk);
    #1;
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
